// File: rtl/fpadd_pipe.sv
// fpadd_pipe: pipelined floating-point adder/subtractor.
// It rounds to nearest, ties to even. Denormal inputs and underflowing results
// are flushed to zero. NaN results are canonical, and OVF flags overflow.
//
// Handshake: ACT marks A/B/SUB/TAGi valid on the rising edge that samples it.
// ACT is ignored while RESET is high. Exactly three edges later, RDY pulses
// high for one cycle, and R/TAGo/NAN/OVF carry that operation's result.
// There is no backpressure and results leave in issue order. The outputs
// hold their values between pulses.
`timescale 1ns/1ps
module fpadd_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TW = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ACT,
  input  logic             SUB,
  input  logic [TW-1:0]    TAGi,
  input  logic [EW+MW:0]   A,
  input  logic [EW+MW:0]   B,
  output logic             RDY,
  output logic [TW-1:0]    TAGo,
  output logic [EW+MW:0]   R,
  output logic             NAN,
  output logic             OVF
);
  localparam int W    = 1 + EW + MW;
  localparam int SW   = MW + 4;          // hidden + mantissa + guard/round/sticky
  localparam int EMAX = (1 << EW) - 1;

  // stage 0: registered operands (B already carries its effective sign)
  logic          v0;
  logic [W-1:0]  a0, b0;
  logic [TW-1:0] tag0;

  // stage 1 combinational: classification, ordering, alignment
  logic          signA, signB, zeroA, zeroB, nanA, nanB, infA, infB, aGeB;
  logic [EW-1:0] expA, expB, expX, expY, expDiff;
  logic [MW-1:0] manA, manB;
  logic          signX;
  logic [SW-1:0] sigX, sigY, lostMask, yAl;

  // stage 1 registers
  logic          v1, sgn1, effSub1, nan1, inf1, infSign1, bothZero1, zeroSign1;
  logic [TW-1:0] tag1;
  logic [EW-1:0] exp1;
  logic [SW-1:0] sigX1, sigY1;

  // stage 2 registers
  logic          v2, sgn2, nan2, inf2, infSign2, bothZero2, zeroSign2;
  logic [TW-1:0] tag2;
  logic [EW-1:0] exp2;
  logic [SW:0]   sum2;

  // stage 3 combinational: normalise, round, special override
  int                  lzCnt;
  logic [SW-1:0]       norm;
  logic signed [31:0]  exp2s, expN, expR;
  logic                roundUp;
  logic [MW+1:0]       rounded;
  logic [MW-1:0]       mant;
  logic [W-1:0]        resNext;
  logic                nanNext, ovfNext;

  // Stage 0: capture operands; only the valid bit is reset
  always_ff @(posedge CLK) begin
    if (RESET) v0 <= 1'b0;
    else       v0 <= ACT;
    a0   <= A;
    b0   <= {B[W-1] ^ SUB, B[W-2:0]};
    tag0 <= TAGi;
  end

  assign signA = a0[W-1];
  assign signB = b0[W-1];
  assign expA  = a0[W-2:MW];
  assign expB  = b0[W-2:MW];
  assign manA  = a0[MW-1:0];
  assign manB  = b0[MW-1:0];
  assign zeroA = (expA == '0);
  assign zeroB = (expB == '0);
  assign nanA  = (&expA) & (|manA);
  assign nanB  = (&expB) & (|manB);
  assign infA  = (&expA) & ~(|manA);
  assign infB  = (&expB) & ~(|manB);
  // denormals count as zero magnitude, so a flushed operand never wins the swap
  assign aGeB  = (zeroA ? '0 : a0[W-2:0]) >= (zeroB ? '0 : b0[W-2:0]);

  // Stage 1 logic: put the larger magnitude in X and shift Y right into G/R/S
  always_comb begin
    signX    = aGeB ? signA : signB;
    expX     = aGeB ? expA : expB;
    expY     = aGeB ? expB : expA;
    sigX     = (aGeB ? zeroA : zeroB) ? '0 : {1'b1, (aGeB ? manA : manB), 3'b000};
    sigY     = (aGeB ? zeroB : zeroA) ? '0 : {1'b1, (aGeB ? manB : manA), 3'b000};
    expDiff  = expX - expY;
    lostMask = ~({SW{1'b1}} << expDiff);
    yAl      = sigY >> expDiff;
    yAl[0]   = yAl[0] | (|(sigY & lostMask));
    // very large distances leave only the sticky bit of Y
    if ({{(32-EW){1'b0}}, expDiff} >= 32'(SW)) yAl = {{(SW-1){1'b0}}, |sigY};
  end

  // Stage 1 register: aligned significands plus special-case flags
  always_ff @(posedge CLK) begin
    if (RESET) v1 <= 1'b0;
    else       v1 <= v0;
    tag1      <= tag0;
    sgn1      <= signX;
    effSub1   <= signA ^ signB;
    exp1      <= expX;
    sigX1     <= sigX;
    sigY1     <= yAl;
    nan1      <= nanA | nanB | (infA & infB & (signA ^ signB));
    inf1      <= infA | infB;
    infSign1  <= infA ? signA : signB;
    bothZero1 <= zeroA & zeroB;
    zeroSign1 <= signA & signB;
  end

  // Stage 2 register: significand add/subtract; X >= Y so the difference is never negative
  always_ff @(posedge CLK) begin
    if (RESET) v2 <= 1'b0;
    else       v2 <= v1;
    tag2      <= tag1;
    sgn2      <= sgn1;
    exp2      <= exp1;
    sum2      <= effSub1 ? ({1'b0, sigX1} - {1'b0, sigY1}) : ({1'b0, sigX1} + {1'b0, sigY1});
    nan2      <= nan1;
    inf2      <= inf1;
    infSign2  <= infSign1;
    bothZero2 <= bothZero1;
    zeroSign2 <= zeroSign1;
  end

  // Stage 3 logic: normalise, round to nearest even, then apply special cases
  always_comb begin
    lzCnt = 0;
    for (int i = 0; i < SW; i++) begin
      if (sum2[i]) lzCnt = SW - 1 - i;
    end
    exp2s = $signed({{(32-EW){1'b0}}, exp2});
    if (sum2[SW]) begin
      norm = {sum2[SW:2], sum2[1] | sum2[0]};
      expN = exp2s + 1;
    end else begin
      norm = sum2[SW-1:0] << lzCnt;
      expN = exp2s - lzCnt;
    end
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, roundUp};
    if (rounded[MW+1]) begin
      mant = rounded[MW:1];
      expR = expN + 1;
    end else begin
      mant = rounded[MW-1:0];
      expR = expN;
    end
    nanNext = 1'b0;
    ovfNext = 1'b0;
    if (nan2) begin
      resNext = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      nanNext = 1'b1;
    end else if (inf2) begin
      resNext = {infSign2, {EW{1'b1}}, {MW{1'b0}}};
    end else if (bothZero2) begin
      resNext = {zeroSign2, {(W-1){1'b0}}};
    end else if (sum2 == '0) begin
      resNext = '0;
    end else if (expR >= EMAX) begin
      resNext = {sgn2, {EW{1'b1}}, {MW{1'b0}}};
      ovfNext = 1'b1;
    end else if (expR <= 0) begin
      resNext = '0;
    end else begin
      resNext = {sgn2, expR[EW-1:0], mant};
    end
  end

  // Output register: RDY pulses per operation, result fields hold otherwise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RDY  <= 1'b0;
      TAGo <= '0;
      R    <= '0;
      NAN  <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      RDY <= v2;
      if (v2) begin
        TAGo <= tag2;
        R    <= resNext;
        NAN  <= nanNext;
        OVF  <= ovfNext;
      end
    end
  end
endmodule

// File: tb/tb_fpadd_pipe.sv
// Bench for fpadd_pipe: single-precision instance with an exact-arithmetic
// reference model feeding an expected queue, plus a half-precision instance.
`timescale 1ns/1ps
module tb_fpadd_pipe;
  localparam int EXPW = 35;   // {tag, nan, ovf, r[31:0]}

  logic        clk = 1'b0;
  logic        reset, act, sub, tag_i;
  logic [31:0] a, b;
  logic        rdy, tag_o, nan_flag, ovf;
  logic [31:0] r;

  logic        h_act, h_sub, h_tag_i;
  logic [15:0] h_a, h_b;
  logic        h_rdy, h_tag_o, h_nan, h_ovf;
  logic [15:0] h_r;

  logic [EXPW-1:0] exp_q[$];
  logic [EXPW-1:0] last_exp;
  int checks = 0;
  int errors = 0;

  fpadd_pipe #(.EW(8), .MW(23), .TW(1)) dut (
    .CLK(clk), .RESET(reset), .ACT(act), .SUB(sub), .TAGi(tag_i),
    .A(a), .B(b), .RDY(rdy), .TAGo(tag_o), .R(r), .NAN(nan_flag), .OVF(ovf)
  );

  fpadd_pipe #(.EW(5), .MW(10), .TW(1)) dut_half (
    .CLK(clk), .RESET(reset), .ACT(h_act), .SUB(h_sub), .TAGi(h_tag_i),
    .A(h_a), .B(h_b), .RDY(h_rdy), .TAGo(h_tag_o), .R(h_r), .NAN(h_nan), .OVF(h_ovf)
  );

  // clock
  always #5 clk = ~clk;

  // reference: exact fixed-point sum in units of 2^-149, then RNE on the remainder
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic s_op);
    logic sa, sb, s;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [299:0] ma, mb, mag, keep, rem, half;
    int p, k, e;
    sa = x[31]; sb = y[31] ^ s_op;
    ea = x[30:23]; eb = y[30:23];
    fa = x[22:0];  fb = y[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
        (ea == 8'hFF && eb == 8'hFF && sa != sb)) return {2'b10, 32'h7FC00000};
    if (ea == 8'hFF) return {2'b00, sa, 8'hFF, 23'h0};
    if (eb == 8'hFF) return {2'b00, sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {2'b00, sa & sb, 31'h0};
    ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 8'd1));
    mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 8'd1));
    if (sa == sb)      begin mag = ma + mb; s = sa; end
    else if (ma >= mb) begin mag = ma - mb; s = sa; end
    else               begin mag = mb - ma; s = sb; end
    if (mag == 0) return 34'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return 34'h0;
    keep = mag;
    if (p > 23) begin
      k = p - 23;
      keep = mag >> k;
      rem  = mag & ((300'(1) << k) - 300'(1));
      half = 300'(1) << (k - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 300'(1);
      if (keep[24]) begin keep = keep >> 1; e++; end
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'h0};
    return {2'b00, s, e[7:0], keep[22:0]};
  endfunction

  // scoreboard: every RDY pops one expected entry
  always @(negedge clk) begin
    if (rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdy got R=%h with empty expected queue", r);
      end else begin
        last_exp = exp_q.pop_front();
        if ({tag_o, nan_flag, ovf, r} !== last_exp) begin
          errors++;
          $display("FAIL result got tag=%b nan=%b ovf=%b r=%h required tag=%b nan=%b ovf=%b r=%h",
                   tag_o, nan_flag, ovf, r, last_exp[34], last_exp[33], last_exp[32], last_exp[31:0]);
        end
      end
    end
  end

  task automatic drive_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_sub, input logic op_tag);
    act = 1'b1; a = op_a; b = op_b; sub = op_sub; tag_i = op_tag;
    exp_q.push_back({op_tag, ref_add(op_a, op_b, op_sub)});
    @(posedge clk); #1;
    act = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d results outstanding required 0", exp_q.size());
    end
  endtask

  task automatic rdy_pattern(output logic [5:0] pat);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = {pat[4:0], rdy};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy, tag_o, r, nan_flag, ovf} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {rdy, tag_o, r, nan_flag, ovf});
    end
    checks++;
    if ({h_rdy, h_tag_o, h_r, h_nan, h_ovf} !== 20'h0) begin
      errors++;
      $display("FAIL reset_half got %h required 0", {h_rdy, h_tag_o, h_r, h_nan, h_ovf});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [5:0] pat;
    drive_op(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    rdy_pattern(pat);
    checks++;
    if (pat !== 6'b000100) begin
      errors++;
      $display("FAIL basic_latency got %b required 000100", pat);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[16], tb[16];
    logic [15:0] ts;
    ta = '{32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
           32'h7FC12345, 32'hFF800000, 32'h7F800000, 32'h00000001, 32'h00800001, 32'h7F7FFFFF,
           32'h80000000, 32'h3F800000, 32'hC0400000, 32'h3F800000};
    tb = '{32'h3F800000, 32'h00000000, 32'h33800000, 32'h33C00000, 32'h7F7FFFFF, 32'h7F800000,
           32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h00800000, 32'h73000000,
           32'h80000000, 32'hBF800000, 32'h3F800000, 32'h33800001};
    ts = 16'b1000_0100_0010_0011;   // bit i is SUB for entry i
    for (int i = 0; i < 16; i++) drive_op(ta[i], tb[i], ts[i], 1'(i));
    wait_drain();
  endtask

  task automatic test_hold();
    repeat (3) @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || {tag_o, nan_flag, ovf, r} !== last_exp) begin
      errors++;
      $display("FAIL hold got rdy=%b fields=%h required rdy=0 fields=%h", rdy, {tag_o, nan_flag, ovf, r}, last_exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    drive_op(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    drive_op(32'h40400000, 32'h3F800000, 1'b1, 1'b1);
    drive_op(32'hC1200000, 32'h41200000, 1'b0, 1'b0);
    drive_op(32'h42C80000, 32'hBF000000, 1'b0, 1'b1);
    rdy_pattern(pat);
    checks++;
    if (pat !== 6'b111100) begin
      errors++;
      $display("FAIL back_to_back_rdy got %b required 111100", pat);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    logic [5:0] pat;
    drive_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
    drive_op(32'h40000000, 32'h3F800000, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({rdy, tag_o, r, nan_flag, ovf} !== 36'h0) begin
      errors++;
      $display("FAIL flush_outputs got %h required 0", {rdy, tag_o, r, nan_flag, ovf});
    end
    rdy_pattern(pat);
    checks++;
    if (pat !== 6'b000000) begin
      errors++;
      $display("FAIL flush_no_rdy got %b required 000000", pat);
    end
    @(posedge clk); #1;
    drive_op(32'h40400000, 32'h3F800000, 1'b0, 1'b0);
    rdy_pattern(pat);
    checks++;
    if (pat !== 6'b000100) begin
      errors++;
      $display("FAIL after_reset_latency got %b required 000100", pat);
    end
    wait_drain();
  endtask

  task automatic test_act_during_reset();
    logic [5:0] pat;
    @(posedge clk); #1;
    reset = 1'b1; act = 1'b1; a = 32'h3F800000; b = 32'h40000000; sub = 1'b0; tag_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    rdy_pattern(pat);
    checks++;
    if (pat !== 6'b000100) begin
      errors++;
      $display("FAIL act_in_reset got %b required 000100", pat);
    end
    wait_drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int ea_i, eb_i, mode, gap;
      logic [22:0] fa, fb;
      mode = int'($urandom_range(0, 19));
      ea_i = int'($urandom_range(1, 254));
      eb_i = ea_i + int'($urandom_range(0, 60)) - 30;
      if (eb_i < 1) eb_i = 1;
      if (eb_i > 254) eb_i = 254;
      fa = 23'($urandom);
      fb = 23'($urandom);
      if (mode == 0) begin eb_i = 255; if (fb[0]) fb = '0; end
      else if (mode == 1) ea_i = 0;
      else if (mode == 2) begin eb_i = ea_i; fb = fa; end
      else if (mode == 3) begin ea_i = int'($urandom_range(245, 254)); eb_i = int'($urandom_range(245, 254)); end
      else if (mode == 4) begin eb_i = ea_i; fb = fa ^ 23'(1 << $urandom_range(0, 22)); end
      drive_op({1'($urandom_range(0, 1)), 8'(ea_i), fa}, {1'($urandom_range(0, 1)), 8'(eb_i), fb},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
    end
    wait_drain();
  endtask

  task automatic test_half();
    logic [15:0] got_r[2];
    logic [2:0]  got_f[2];
    int n, waited;
    h_a = 16'h3C00; h_b = 16'h3C00; h_sub = 1'b0; h_tag_i = 1'b0; h_act = 1'b1;
    @(posedge clk); #1;
    h_a = 16'h7BFF; h_b = 16'h7BFF; h_tag_i = 1'b1;
    @(posedge clk); #1;
    h_act = 1'b0;
    n = 0; waited = 0;
    got_r[0] = 'x; got_r[1] = 'x; got_f[0] = 'x; got_f[1] = 'x;
    while (n < 2 && waited < 20) begin
      @(negedge clk);
      waited++;
      if (h_rdy === 1'b1) begin
        got_r[n] = h_r; got_f[n] = {h_tag_o, h_nan, h_ovf}; n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL half_count got %0d required 2", n); end
    checks++;
    if (got_r[0] !== 16'h4000 || got_f[0] !== 3'b000) begin
      errors++; $display("FAIL half_add got r=%h f=%b required r=4000 f=000", got_r[0], got_f[0]);
    end
    checks++;
    if (got_r[1] !== 16'h7C00 || got_f[1] !== 3'b101) begin
      errors++; $display("FAIL half_ovf got r=%h f=%b required r=7c00 f=101", got_r[1], got_f[1]);
    end
  endtask

  initial begin
    reset = 1'b1; act = 1'b0; sub = 1'b0; tag_i = 1'b0; a = '0; b = '0;
    h_act = 1'b0; h_sub = 1'b0; h_tag_i = 1'b0; h_a = '0; h_b = '0;
    last_exp = '0;
    test_reset();
    test_basic();
    wait_drain();
    test_directed();
    test_hold();
    test_back_to_back();
    test_flush();
    test_act_during_reset();
    test_random();
    test_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpadd_pipe.md
# fpadd_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with round-to-nearest-even, canonical NaN and overflow flags, and a pass-through tag. It is the next-generation FP add unit for the X32/X16 execution cores. Exponent, mantissa and tag widths are generic, so single and reduced-precision formats share one unit. It accepts one operation per clock, has a fixed 3-cycle latency, and keeps the ACT/RDY/TAG handshake used by the other arithmetic cores.

## Interface
- EW, 8: exponent width (≥4)
- MW, 23: stored mantissa width, hidden bit excluded (≥4)
- TW, 1: tag width
- Word width W = 1+EW+MW; sign at W-1, exponent [W-2:MW], mantissa [MW-1:0]
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ACT  in  1  operation valid this cycle
- SUB  in  1  1: R = A - B; 0: R = A + B (sampled with ACT)
- TAGi  in  TW  user tag, sampled with ACT
- A, B  in  W  operands, sampled with ACT
- RDY  out  1  one-cycle pulse: R/TAGo/flags carry a new result
- TAGo  out  TW  tag of the result presented with RDY
- R  out  W  result register
- NAN  out  1  result is NaN (NaN input or invalid operation)
- OVF  out  1  finite operands overflowed to infinity

## Operation
- Effective B sign = B[W-1] ^ SUB.
- Denormal inputs (exponent 0) are flushed to signed zero before use. The result never denormalises: an underflowing result flushes to +0.
- Stage 1, align and classify:
  - Swap operands so X has magnitude ≥ Y.
  - Right-shift Y's significand (hidden bit + MW) by expX-expY, keeping guard, round and sticky bits.
  - A shift ≥ MW+3 collapses Y to sticky only.
  - Classify the inputs as NaN, Inf or zero.
- Stage 2, add: add or subtract the significands according to the effective signs. The adder is MW+5 bits wide (carry + hidden + MW + G/R/S), so it cannot overflow. Result sign is sign(X).
- Stage 3, normalise and round:
  - Leading-one detect, then shift left, or shift right by 1 on carry; adjust the exponent.
  - Round to nearest, ties to even, using G/R/S. A rounding carry re-normalises and increments the exponent.
  - Exponent ≥ 2^EW-1 after rounding gives ±Inf and OVF=1.
  - Exponent ≤ 0 gives +0.
- Exact cancellation (X-Y = 0) gives +0. (+0)+(+0) gives +0. (-0)+(-0) gives -0.
- Specials override the arithmetic result:
  - Any NaN input, or Inf + (-Inf) effective, gives canonical NaN: sign 0, exponent all ones, mantissa MSB 1, rest 0. NAN=1.
  - Inf with a finite operand gives that Inf; OVF=0.
  - Inf + same-signed Inf gives that Inf.
- The SUB, tag, valid and special-case flags travel through the pipeline alongside the data.

## Timing
- Latency: ACT sampled at edge t gives RDY=1 after edge t+3, with R, TAGo, NAN and OVF valid in the same cycle.
- Throughput is one operation per cycle. Back-to-back ACT gives back-to-back RDY in issue order.
- RDY is a one-cycle pulse per operation. R, TAGo, NAN and OVF hold their last values while RDY=0.
- There is no backpressure; the consumer must accept every RDY.
- Reset values: RDY=0, TAGo=0, R=0, NAN=0, OVF=0, all pipeline valid bits cleared.
- RESET at any edge flushes in-flight operations; no RDY is produced for them.
- ACT sampled in the same cycle as RESET is ignored.
- ACT in the first cycle after RESET deasserts is accepted normally.
- Pipeline data registers need no reset; only valid bits and outputs are reset.

## Test plan
- EW=8, MW=23. ACT with A=0x3F800000, B=0x40000000, SUB=0, TAGi=1 → 3 cycles later RDY=1, R=0x40400000, TAGo=1, NAN=0, OVF=0.
- A=0x3F800000, B=0x3F800000, SUB=1 → R=0x00000000. A=0x80000000, B=0x00000000, SUB=1 → R=0x80000000.
- Rounding ties to even: A=0x3F800000, B=0x33800000 → R=0x3F800000. A=0x3F800000, B=0x33C00000 → R=0x3F800001.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → R=0x7F800000, OVF=1.
  - 0x7F800000 SUB 0x7F800000 → R=0x7FC00000, NAN=1.
  - 0x7FC12345 + 0x3F800000 → R=0x7FC00000, NAN=1.
- Pipeline and reset:
  - Four consecutive ACTs with tags 0,1,0,1 → four consecutive RDY pulses, results and tags in order.
  - Assert RESET one cycle after the 2nd ACT → no further RDY, all outputs 0 the cycle after reset.
  - Next ACT after reset completes in 3 cycles.
- Parametrisation: EW=5, MW=10, A=0x3C00 (1.0), B=0x3C00, SUB=0 → R=0x4000. 0x7BFF + 0x7BFF → R=0x7C00, OVF=1.
